// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// One full-subtractor cell and a registered borrow process one bit per clock.
// Handshake: start (sampled while not busy), busy during the WIDTH bit edges,
// and a one-cycle done pulse that qualifies diff/borrow_out.
// Optional feature: define SERIAL_SUB_OVF_EN to add the registered signed
// overflow output; without it the overflow port and its logic are absent.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell operating on the current LSBs of the operand shifters.
  logic a_bit, b_bit, d_bit, br_next;

  assign a_bit   = a_sr_q[0];
  assign b_bit   = b_sr_q[0];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  // Next-state and datapath update; every _d holds its value by default.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Accept: DONE behaves like IDLE here, which gives back-to-back ops.
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        // New bit enters at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        br_d   = br_next;
        if (cnt_q == LastBit) begin
          cnt_d    = '0;
          borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit a_bit/b_bit are the latched operand MSBs and
          // d_bit becomes diff[WIDTH-1].
          ovf_d    = (a_bit != b_bit) && (d_bit != a_bit);
`endif
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears results so an aborted op leaves zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8).
// A cycle-level model of the handshake pushes expected results computed with
// plain arithmetic; a monitor pops them on every done pulse.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf_act;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
  assign ovf_act = overflow;
`else
  assign ovf_act = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } result_t;

  result_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 0;

  // Model: cycles of busy remaining after an accept, and whether done is due.
  int      busy_left = 0;
  bit      exp_done  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic result_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    result_t r;
    int sx, sy, sd;
    r.d  = W'(x - y);
    r.br = (x < y);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    sd   = sx - sy;
`ifdef SERIAL_SUB_OVF_EN
    r.ov = (sd > 127) || (sd < -128);
`else
    r.ov = 1'b0;
`endif
    return r;
  endfunction

  // Reference handshake model, evaluated on the same edges the DUT samples.
  always @(posedge clk) begin
    if (reset) begin
      busy_left = 0;
      exp_done  = 0;
      exp_q.delete();
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      exp_done  = (busy_left == 0);
    end else begin
      exp_done = 0;
      if (start) begin
        exp_q.push_back(ref_sub(a, b));
        busy_left = W;
      end
    end
  end

  // Monitor: handshake every cycle, results whenever done is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(busy_left > 0));
      chk("done", 32'(done), 32'(exp_done));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          result_t r;
          r = exp_q.pop_front();
          chk("diff", 32'(diff), 32'(r.d));
          chk("borrow_out", 32'(borrow_out), 32'(r.br));
          chk("overflow", 32'(ovf_act), 32'(r.ov));
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    result_t r;
    r = ref_sub(x, y);
    a = x;
    b = y;
    start = 1;
    @(negedge clk);
    start = 0;
    // Operands may change after the accepting edge.
    a = W'($urandom);
    b = W'($urandom);
    repeat (W + 1) @(negedge clk);
    chk("held_diff", 32'(diff), 32'(r.d));
    chk("held_borrow", 32'(borrow_out), 32'(r.br));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_diff"}, 32'(diff), 0);
    chk({tag, "_borrow"}, 32'(borrow_out), 0);
    chk({tag, "_ovf"}, 32'(ovf_act), 0);
  endtask

  initial begin
    reset = 1;
    start = 0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    mon_en = 1;
    chk_zero("reset");

    run_op(8'd100, 8'd58);
    run_op(8'd5, 8'd7);
    run_op(8'd0, 8'd0);
    run_op(8'h80, 8'h01);
    run_op(8'h10, 8'h20);
    run_op(8'hFF, 8'hFF);
    run_op(8'h7F, 8'h80);

    // Continuous start: back-to-back results every W+1 cycles.
    a = 8'd200;
    b = 8'd1;
    start = 1;
    repeat (3 * (W + 1)) @(negedge clk);
    start = 0;
    repeat (W + 1) @(negedge clk);

    // Reset during bit 4 aborts the operation with no done pulse.
    a = 8'd50;
    b = 8'd20;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk_zero("abort");
    repeat (3) @(negedge clk);
    run_op(8'd9, 8'd4);

    // Start pulse during busy is ignored.
    a = 8'd30;
    b = 8'd12;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    a = 8'd1;
    b = 8'd2;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (W + 1) @(negedge clk);

    // Random traffic with random start density and operand churn.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    start = 0;
    repeat (W + 2) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor: computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow flip-flop. It is the inverse arithmetic counterpart to the team's registered full adder and uses a start/busy/done handshake. It sits between the DIP-switch operand capture and the LED result display, and is reusable wherever an area-minimal subtract is needed.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend (unsigned or two's complement); sampled on the accepting edge
b  input  WIDTH  subtrahend; sampled on the accepting edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: diff/borrow_out valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
borrow_out  output  1  final borrow (1 when a < b unsigned); held with diff
overflow  output  1  signed overflow flag (present only with SERIAL_SUB_OVF_EN, see below)

Behaviour:
- Reset (sampled at a posedge with reset=1): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, bit counter=0, internal borrow=0. Reset has priority over every other input and aborts an operation in progress; no done pulse is issued for the aborted operation.
- States: IDLE, SHIFT, DONE.
  - IDLE: if start=1, latch a and b into shift registers, clear the borrow FF, clear the counter, clear diff, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: busy=1. Each edge processes bit i=counter:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - Shift d_i into diff from the MSB side so that after WIDTH edges diff[0] holds bit 0.
    - counter increments. On the edge processing bit WIDTH-1, borrow_out <= br' and the state goes to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. Next edge: if start=1, accept new operands exactly as in IDLE (back-to-back operation); else go to IDLE.
- Latency: start is sampled high at edge E0. busy=1 in cycles E0..E0+WIDTH-1. done=1 in the cycle following edge E0+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no queuing, and operands are not resampled. a and b may change freely after the accepting edge.
- diff/borrow_out are stable from done until the edge that accepts the next start. Mid-operation values of diff are undefined to the consumer; only done qualifies them.
- Wrap: the result is always modulo 2^WIDTH. a=b gives diff=0, borrow_out=0.
- The counter width is clog2(WIDTH) bits and never exceeds WIDTH-1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: the overflow port exists. It is registered on the same edge as borrow_out: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched operand MSBs. It resets to 0 and is held with diff.
- Undefined: the overflow port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=100, b=58, start one cycle -> busy for 8 cycles, done pulse on cycle 9 after the start edge, diff=42, borrow_out=0.
- a=5, b=7 -> diff=0xFE, borrow_out=1. Also a=0, b=0 -> diff=0x00, borrow_out=0.
- Hold start=1 continuously with a=200, b=1 -> results 199 every 9 cycles, with done asserting on each DONE cycle and the next op accepted in that same cycle. Change a/b during busy -> result still reflects the accepted operands.
- Start a=50, b=20, assert reset at bit 4 for one cycle -> no done pulse, all outputs 0, state IDLE. A new start with a=9, b=4 then yields diff=5.
- Pulse start during busy -> ignored; exactly one done pulse and correct diff for the original operands.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0. a=0x10, b=0x20 -> diff=0xF0, overflow=0, borrow_out=1.
